bit_serializer: RTL and testbench

- Transmit-side counterpart to the hash core's serial bit-length counter.
- Accepts message words over a valid/ready handshake and emits them one bit per cycle, LSB first, on a serial data/enable interface that feeds the absorb-side length logic.
- Tracks the number of bits emitted for the current message and pulses done after the final bit of the word marked last.

---
 rtl/bit_serializer.sv | 143 ++++++++++++++
 tb/tb_bit_serializer.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bit_serializer.sv
// Word-to-bit serializer: accepts WIDTH-bit words over valid/ready and emits them LSB first,
// counting emitted bits per message and pulsing done after the final bit of the last word.
//
// state | meaning
// IDLE  | ready for the first word of a message; bit_count holds the previous total
// SHIFT | emitting bits; r_word_vld=0 means waiting between words with din_ready high
// DONE  | one-cycle done pulse, bit_count holds the message total
module bit_serializer #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 12
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    input  logic             din_last,
    output logic             din_ready,
    output logic             serial_out,
    output logic             serial_en,
    input  logic             serial_ready,
    output logic             serial_last,
    output logic [CNT_W-1:0] bit_count,
    output logic             done,
    output logic             overflow
);

    localparam int               IDX_W    = $clog2(WIDTH);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [WIDTH-1:0]   r_shreg;
    logic               r_last;
    logic [IDX_W-1:0]   r_bit_idx;
    logic               r_word_vld;
    logic [CNT_W-1:0]   r_bit_count;
    logic               r_overflow;

    logic               w_consume;
    logic               w_boundary;
    logic               w_ready;
    logic               w_done;
    logic               w_accept;
    logic               w_msg_start;

    assign serial_en  = (r_state == SHIFT) && r_word_vld;
    assign w_consume  = serial_en && serial_ready;
    assign w_boundary = w_consume && (r_bit_idx == LAST_IDX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_ready     = 1'b0;
        w_done      = 1'b0;
        case (r_state)
            IDLE: begin
                w_ready = 1'b1;
                if (din_valid) begin
                    w_state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                if (!r_word_vld) begin
                    w_ready = 1'b1;
                end else if (w_boundary) begin
                    if (r_last) begin
                        w_state_nxt = DONE;
                    end else begin
                        // Ready on the last bit lets the next word follow with no bubble.
                        w_ready = 1'b1;
                    end
                end
            end
            DONE: begin
                w_done      = 1'b1;
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    assign w_accept    = din_valid && w_ready;
    assign w_msg_start = w_accept && (r_state == IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shreg     <= '0;
            r_last      <= 1'b0;
            r_bit_idx   <= '0;
            r_word_vld  <= 1'b0;
            r_bit_count <= '0;
            r_overflow  <= 1'b0;
        end else begin
            if (w_accept) begin
                r_shreg    <= din;
                r_last     <= din_last;
                r_bit_idx  <= '0;
                r_word_vld <= 1'b1;
            end else if (w_consume) begin
                r_shreg   <= {1'b0, r_shreg[WIDTH-1:1]};
                r_bit_idx <= w_boundary ? '0 : r_bit_idx + IDX_W'(1);
                if (w_boundary) begin
                    r_word_vld <= 1'b0;
                end
            end

            // Only the first word of a message restarts the count; later words continue it.
            if (w_msg_start) begin
                r_bit_count <= '0;
                r_overflow  <= 1'b0;
            end else if (w_consume) begin
                if (&r_bit_count) begin
                    r_overflow <= 1'b1;
                end else begin
                    r_bit_count <= r_bit_count + CNT_W'(1);
                end
            end
        end
    end

    assign din_ready   = w_ready;
    assign serial_out  = serial_en && r_shreg[0];
    assign serial_last = serial_en && r_last && (r_bit_idx == LAST_IDX);
    assign bit_count   = r_bit_count;
    assign done        = w_done;
    assign overflow    = r_overflow;

endmodule

// File: tb/tb_bit_serializer.sv
// Bench for bit_serializer: a message table drives words, expected bits and done totals are
// queued on accept and compared as the serializer emits them.
module tb_bit_serializer;

    localparam int W  = 8;
    localparam int CW = 12;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [W-1:0]  din = '0;
    logic          din_valid = 1'b0;
    logic          din_last = 1'b0;
    logic          din_ready;
    logic          serial_out;
    logic          serial_en;
    logic          serial_ready = 1'b1;
    logic          serial_last;
    logic [CW-1:0] bit_count;
    logic          done;
    logic          overflow;

    bit_serializer #(.WIDTH(W), .CNT_W(CW)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .din          (din),
        .din_valid    (din_valid),
        .din_last     (din_last),
        .din_ready    (din_ready),
        .serial_out   (serial_out),
        .serial_en    (serial_en),
        .serial_ready (serial_ready),
        .serial_last  (serial_last),
        .bit_count    (bit_count),
        .done         (done),
        .overflow     (overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         n;
        logic [7:0] w0;
        logic [7:0] w1;
        logic [7:0] w2;
        int         gap;
        int         rmode;
        int         exp_cnt;
        logic       exp_ovf;
        int         exp_run;
        int         exp_lat;
    } msg_t;

    typedef struct {
        logic b;
        logic l;
        int   idx;
        logic lw;
    } bit_t;

    typedef struct {
        int   cnt;
        logic ovf;
        int   run;
    } done_t;

    bit_t  q[$];
    done_t dq[$];
    done_t d_cur;
    msg_t  tbl[7];

    int   nerr = 0;
    int   nchk = 0;
    int   cyc = 0;
    bit   mon_en = 1'b0;
    int   mcnt = 0;
    logic movf = 1'b0;
    bit   tb_first = 1'b0;
    int   en_run = 0;
    int   acc_cyc = 0;
    int   done_cyc = 0;
    int   rmode = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        nchk++;
        if (act != exp) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d at cycle %0d", name, act, exp, cyc);
        end
    endtask

    function automatic logic [7:0] word_of(input msg_t m, input int i);
        case (i)
            0:       return m.w0;
            1:       return m.w1;
            2:       return m.w2;
            default: return 8'(i * 37 + 11);
        endcase
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rmode == 0) serial_ready = 1'b1;
            else            serial_ready = ~serial_ready;
        end
    end

    always @(negedge clk) begin
        if (mon_en) begin
            if (serial_en) begin
                chk("bit_expected", q.size() > 0, 1);
                if (q.size() > 0) begin
                    chk("serial_out", serial_out, q[0].b);
                    chk("serial_last", serial_last, q[0].l);
                    chk("din_ready_shift", din_ready,
                        serial_ready && (q[0].idx == W - 1) && !q[0].lw);
                    if (serial_ready) void'(q.pop_front());
                end
            end else begin
                chk("din_ready_idle", din_ready, !done);
            end
            chk("bit_count", bit_count, mcnt);
            chk("overflow", overflow, movf);
            if (done) begin
                chk("done_expected", dq.size() > 0, 1);
                if (dq.size() > 0) begin
                    d_cur = dq.pop_front();
                    chk("done_count", bit_count, d_cur.cnt);
                    chk("done_ovf", overflow, d_cur.ovf);
                    if (d_cur.run >= 0) chk("contig_run", en_run, d_cur.run);
                    done_cyc = cyc;
                end
            end
            if (serial_en) en_run++;
            else           en_run = 0;
            if (din_valid && din_ready && tb_first) begin
                mcnt = 0;
                movf = 1'b0;
            end else if (serial_en && serial_ready) begin
                if (mcnt == 4095) movf = 1'b1;
                else              mcnt++;
            end
        end
    end

    task automatic wait_accept();
        int  k;
        logic ok;
        k  = 0;
        ok = 1'b0;
        while (!ok && k < 1000) begin
            @(negedge clk);
            ok = din_ready;
            @(posedge clk);
            k++;
        end
        #1;
        chk("accept_in_time", ok, 1);
    endtask

    task automatic push_word(input logic [7:0] w, input logic lw);
        for (int b = 0; b < W; b++) q.push_back('{w[b], lw && (b == W - 1), b, lw});
    endtask

    task automatic send_msg(input msg_t m);
        int k;
        logic [7:0] w;
        rmode    = m.rmode;
        tb_first = 1'b1;
        for (int i = 0; i < m.n; i++) begin
            w = word_of(m, i);
            if (i > 0 && m.gap > 0) begin
                din_valid = 1'b0;
                k = 0;
                do begin
                    @(negedge clk);
                    k++;
                end while (serial_en && k < 200);
                chk("gap_reached", serial_en, 0);
                repeat (m.gap - 1) @(posedge clk);
                #1;
            end
            din       = w;
            din_last  = (i == m.n - 1);
            din_valid = 1'b1;
            wait_accept();
            acc_cyc  = cyc;
            tb_first = 1'b0;
            push_word(w, din_last);
            if (din_last) dq.push_back('{m.exp_cnt, m.exp_ovf, m.exp_run});
        end
        din_valid = 1'b0;
        din       = 8'($urandom);
        din_last  = 1'($urandom_range(0, 1));
        k = 0;
        while ((dq.size() != 0 || q.size() != 0) && k < 10000) begin
            @(posedge clk);
            k++;
        end
        chk("msg_complete", dq.size() + q.size(), 0);
        @(posedge clk);
        #1;
        // done is expected WIDTH cycles after the accept cycle's successor, i.e. N+1+WIDTH
        if (m.exp_lat > 0) chk("done_latency", done_cyc - acc_cyc, m.exp_lat);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        //          n    w0     w1     w2    gap rm cnt  ovf run  lat
        tbl[0] = '{1,   8'hA5, 8'h00, 8'h00, 0, 0, 8,    0, 8,    8};
        tbl[1] = '{3,   8'h01, 8'hFF, 8'h80, 0, 0, 24,   0, 24,   0};
        tbl[2] = '{1,   8'h3C, 8'h00, 8'h00, 0, 1, 8,    0, -1,   0};
        tbl[3] = '{2,   8'hC3, 8'h5A, 8'h00, 3, 0, 16,   0, 8,    0};
        tbl[4] = '{512, 8'h00, 8'h00, 8'h00, 0, 0, 4095, 1, 4096, 0};
        tbl[5] = '{1,   8'h96, 8'h00, 8'h00, 0, 0, 8,    0, 8,    8};
        tbl[6] = '{1,   8'h0F, 8'h00, 8'h00, 0, 0, 8,    0, 8,    8};

        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_serial_out", serial_out, 0);
        chk("rst_serial_en", serial_en, 0);
        chk("rst_serial_last", serial_last, 0);
        chk("rst_done", done, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_bit_count", bit_count, 0);
        chk("rst_din_ready", din_ready, 1);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        mon_en = 1'b1;

        for (int m = 0; m < 6; m++) send_msg(tbl[m]);

        // Reset in the middle of a word: outputs clear at once and no done follows.
        rmode     = 0;
        tb_first  = 1'b1;
        din       = 8'hB6;
        din_last  = 1'b1;
        din_valid = 1'b1;
        wait_accept();
        tb_first  = 1'b0;
        din_valid = 1'b0;
        push_word(8'hB6, 1'b1);
        dq.push_back('{8, 1'b0, 8});
        repeat (4) @(posedge clk);
        #2;
        chk("pre_reset_bit4", serial_out, 1);
        chk("pre_reset_count", bit_count, 4);
        mon_en = 1'b0;
        rst_n  = 1'b0;
        #1;
        chk("midrst_serial_out", serial_out, 0);
        chk("midrst_serial_en", serial_en, 0);
        chk("midrst_serial_last", serial_last, 0);
        chk("midrst_done", done, 0);
        chk("midrst_overflow", overflow, 0);
        chk("midrst_bit_count", bit_count, 0);
        q.delete();
        dq.delete();
        mcnt   = 0;
        movf   = 1'b0;
        en_run = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        mon_en = 1'b1;
        repeat (12) @(posedge clk);
        #1;
        send_msg(tbl[6]);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
